// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: row drive, column sync/debounce, hex-code accumulator.
// Optional feature macro: KEYPAD_ACCUM_EN (8-digit shift accumulator on `data`).
module keypad_scan #(
  parameter logic [19:0] SCAN_T     = 20'd50000,
  parameter int unsigned DEBOUNCE_N = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col_in,
  input  logic        rd_en,
  output logic [3:0]  row_out,
  output logic [3:0]  key_code,
  output logic [31:0] data,
  output logic        data_en,
  output logic        key_pending,
  output logic        overrun
);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_WAIT_REL = 2'd2
  } state_t;

  localparam logic [3:0] DEB_N = DEBOUNCE_N[3:0];

  state_t      state_r, state_s;
  logic [3:0]  sync_meta_r;
  logic [3:0]  col_s_r;
  logic [19:0] cnt_r;
  logic        tick_s;
  logic [3:0]  cap_r, cap_s;
  logic [3:0]  mcnt_r, mcnt_s;
  logic [3:0]  row_s;
  logic        accept_s;
  logic [3:0]  code_s;

  // True when exactly one of the four active-low lines is asserted.
  function automatic logic one_low(input logic [3:0] v);
    case (v)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
      default:                            one_low = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    case (v)
      4'b1110: low_idx = 2'd0;
      4'b1101: low_idx = 2'd1;
      4'b1011: low_idx = 2'd2;
      4'b0111: low_idx = 2'd3;
      default: low_idx = 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] rotate(input logic [3:0] v);
    rotate = {v[2:0], v[3]};
  endfunction

  assign tick_s = (cnt_r == (SCAN_T - 20'd1));
  // code = row*4 + col; the captured columns equal col_s whenever an accept fires
  assign code_s = {low_idx(row_out), low_idx(cap_r)};

  // Two-flop synchronizer for the asynchronous column inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta_r <= 4'hF;
      col_s_r     <= 4'hF;
    end else begin
      sync_meta_r <= col_in;
      col_s_r     <= sync_meta_r;
    end
  end

  // Row-slot counter; a tick marks the last cycle of each slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 20'd0;
    end else if (tick_s) begin
      cnt_r <= 20'd0;
    end else begin
      cnt_r <= cnt_r + 20'd1;
    end
  end

  // Scan FSM state, match counter, captured columns and row drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_SCAN;
      mcnt_r  <= 4'd0;
      cap_r   <= 4'hF;
      row_out <= 4'b1110;
    end else begin
      state_r <= state_s;
      mcnt_r  <= mcnt_s;
      cap_r   <= cap_s;
      row_out <= row_s;
    end
  end

  // Next-state logic; everything only moves on a tick.
  always_comb begin
    state_s  = state_r;
    mcnt_s   = mcnt_r;
    cap_s    = cap_r;
    row_s    = row_out;
    accept_s = 1'b0;
    if (tick_s) begin
      case (state_r)
        ST_SCAN: begin
          // ghosts and multi-presses (two or more lows) are skipped like an idle row
          if (one_low(col_s_r)) begin
            cap_s   = col_s_r;
            mcnt_s  = 4'd1;
            state_s = ST_DEBOUNCE;
          end else begin
            row_s = rotate(row_out);
          end
        end
        ST_DEBOUNCE: begin
          if (col_s_r == cap_r) begin
            if ((mcnt_r + 4'd1) == DEB_N) begin
              accept_s = 1'b1;
              mcnt_s   = 4'd0;
              state_s  = ST_WAIT_REL;
            end else begin
              mcnt_s = mcnt_r + 4'd1;
            end
          end else begin
            mcnt_s  = 4'd0;
            row_s   = rotate(row_out);
            state_s = ST_SCAN;
          end
        end
        ST_WAIT_REL: begin
          if (col_s_r == 4'hF) begin
            if ((mcnt_r + 4'd1) == DEB_N) begin
              mcnt_s  = 4'd0;
              row_s   = rotate(row_out);
              state_s = ST_SCAN;
            end else begin
              mcnt_s = mcnt_r + 4'd1;
            end
          end else begin
            mcnt_s = 4'd0;
          end
        end
        default: begin
          mcnt_s  = 4'd0;
          cap_s   = 4'hF;
          row_s   = 4'b1110;
          state_s = ST_SCAN;
        end
      endcase
    end else begin
      accept_s = 1'b0;
    end
  end

  // Key result registers; an accept beats a simultaneous read acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_code    <= 4'd0;
      data        <= 32'd0;
      data_en     <= 1'b0;
      key_pending <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      data_en <= accept_s;
      if (accept_s) begin
        key_code    <= code_s;
`ifdef KEYPAD_ACCUM_EN
        data        <= {data[27:0], code_s};
`else
        data        <= {28'd0, code_s};
`endif
        key_pending <= 1'b1;
        overrun     <= overrun | key_pending;
      end else if (rd_en) begin
        key_pending <= 1'b0;
      end else begin
        key_pending <= key_pending;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan (SCAN_T=4, DEBOUNCE_N=3) with a behavioural keypad matrix.
module tb_keypad_scan;

  logic        clk;
  logic        rst;
  logic [3:0]  col_in;
  logic        rd_en;
  logic [3:0]  row_out;
  logic [3:0]  key_code;
  logic [31:0] data;
  logic        data_en;
  logic        key_pending;
  logic        overrun;

  logic [15:0] keys;
  int          errors = 0;
  int          checks = 0;
  int          pulses = 0;

`ifdef KEYPAD_ACCUM_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  typedef struct {
    logic [3:0]  key;
    logic        rd;
    logic [31:0] acc_data;
    logic        pend;
    logic        ovr;
  } vec_t;

  vec_t vecs [6];

  keypad_scan #(.SCAN_T(20'd4), .DEBOUNCE_N(3)) dut (
    .clk(clk), .rst(rst), .col_in(col_in), .rd_en(rd_en),
    .row_out(row_out), .key_code(key_code), .data(data), .data_en(data_en),
    .key_pending(key_pending), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row_out[r] && keys[r*4+c]) col_in[c] = 1'b0;
      end
    end
  end

  always @(negedge clk) if (data_en) pulses++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] rot_row(input int n);
    logic [3:0] r;
    r = 4'b1110;
    for (int i = 0; i < n; i++) r = {r[2:0], r[3]};
    return r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, " row_out"}, {28'd0, row_out}, 32'hE);
    check({tag, " key_code"}, {28'd0, key_code}, 32'd0);
    check({tag, " data"}, data, 32'd0);
    check({tag, " data_en"}, {31'd0, data_en}, 32'd0);
    check({tag, " key_pending"}, {31'd0, key_pending}, 32'd0);
    check({tag, " overrun"}, {31'd0, overrun}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns at the negedge just after row 0 becomes driven (a tick edge).
  task automatic wait_row0_start(input string tag);
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    prev = row_out;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (row_out == 4'b1110 && prev != 4'b1110) begin
        found = 1'b1;
        break;
      end
      prev = row_out;
    end
    check({tag, " row0 start seen"}, {31'd0, found}, 32'd1);
  endtask

  task automatic press_vec(input vec_t v, input string tag);
    bit seen;
    logic [31:0] exp_data;
    seen = 1'b0;
    exp_data = ACC ? v.acc_data : {28'd0, v.key};
    keys = 16'd1 << v.key;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (data_en) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, " data_en seen"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      check({tag, " key_code"}, {28'd0, key_code}, {28'd0, v.key});
      check({tag, " data"}, data, exp_data);
      check({tag, " key_pending"}, {31'd0, key_pending}, {31'd0, v.pend});
      check({tag, " overrun"}, {31'd0, overrun}, {31'd0, v.ovr});
    end
    keys = 16'd0;
    repeat (24) @(negedge clk);
    if (v.rd) begin
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      check({tag, " pending cleared"}, {31'd0, key_pending}, 32'd0);
    end
  endtask

  initial begin
    int p0;
    bit got;
    bit moved;
    vecs[0] = '{key: 4'h1, rd: 1'b1, acc_data: 32'h0000_0001, pend: 1'b1, ovr: 1'b0};
    vecs[1] = '{key: 4'h2, rd: 1'b1, acc_data: 32'h0000_0012, pend: 1'b1, ovr: 1'b0};
    vecs[2] = '{key: 4'h3, rd: 1'b1, acc_data: 32'h0000_0123, pend: 1'b1, ovr: 1'b0};
    vecs[3] = '{key: 4'hA, rd: 1'b1, acc_data: 32'h0000_123A, pend: 1'b1, ovr: 1'b0};
    vecs[4] = '{key: 4'hB, rd: 1'b0, acc_data: 32'h0001_23AB, pend: 1'b1, ovr: 1'b0};
    vecs[5] = '{key: 4'hC, rd: 1'b0, acc_data: 32'h0012_3ABC, pend: 1'b1, ovr: 1'b1};

    rst = 1'b1;
    rd_en = 1'b0;
    keys = 16'd0;

    // Reset values and idle scan sequence
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("idle row[%0d]", i), {28'd0, row_out}, {28'd0, rot_row(((i + 1) / 4) % 4)});
    end

    // Long hold of key 6 (row1/col2): one accept, row frozen until release settles
    p0 = pulses;
    got = 1'b0;
    keys = 16'd1 << 6;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (data_en && !got) begin
        got = 1'b1;
        check("hold key_code", {28'd0, key_code}, 32'd6);
        check("hold data", data, 32'h0000_0006);
        check("hold key_pending", {31'd0, key_pending}, 32'd1);
        check("hold overrun", {31'd0, overrun}, 32'd0);
      end
    end
    check("hold pulses", pulses - p0, 32'd1);
    check("hold row frozen", {28'd0, row_out}, 32'hD);
    keys = 16'd0;
    repeat (8) @(negedge clk);
    check("release row still frozen", {28'd0, row_out}, 32'hD);
    moved = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (row_out != 4'b1101) begin
        moved = 1'b1;
        break;
      end
    end
    check("scan resumed", {31'd0, moved}, 32'd1);

    // Key sequence with and without reads
    do_reset();
    for (int i = 0; i < 6; i++) press_vec(vecs[i], $sformatf("vec%0d", i));

    // Read acknowledge in the same cycle as the accept of key 3
    wait_row0_start("rd_same");
    keys = 16'd1 << 3;
    repeat (11) @(negedge clk);
    check("rd_same pending before", {31'd0, key_pending}, 32'd1);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("rd_same data_en", {31'd0, data_en}, 32'd1);
    check("rd_same key_pending", {31'd0, key_pending}, 32'd1);
    check("rd_same overrun", {31'd0, overrun}, 32'd1);
    check("rd_same key_code", {28'd0, key_code}, 32'd3);
    check("rd_same data", data, ACC ? 32'h0123_ABC3 : 32'h0000_0003);
    keys = 16'd0;
    repeat (24) @(negedge clk);

    // One-tick bounce on row 0 col 1
    wait_row0_start("bounce");
    p0 = pulses;
    keys = 16'd1 << 1;
    repeat (5) @(negedge clk);
    check("bounce row frozen", {28'd0, row_out}, 32'hE);
    keys = 16'd0;
    repeat (3) @(negedge clk);
    check("bounce row rotated", {28'd0, row_out}, 32'hD);
    repeat (40) @(negedge clk);
    check("bounce no accept", pulses - p0, 32'd0);

    // Two columns low on one row: ghost, never accepted
    p0 = pulses;
    keys = 16'h0003;
    repeat (60) @(negedge clk);
    check("ghost no accept", pulses - p0, 32'd0);
    keys = 16'd0;
    repeat (8) @(negedge clk);

    // Reset in the middle of DEBOUNCE
    wait_row0_start("mid_rst");
    p0 = pulses;
    keys = 16'd1 << 2;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    keys = 16'd0;
    repeat (2) @(negedge clk);
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("mid_rst no accept", pulses - p0, 32'd0);
    check("mid_rst data", data, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

4x4 matrix keypad scanner: the input-side counterpart of the 8-digit hex display driver. Drives one row low at a time, samples the active-low columns, debounces, and converts each accepted press into a 4-bit hex code. Codes are shifted into a 32-bit word whose format matches the display's `data`/`data_en` inputs, so a keypad press can be echoed directly or read by the CPU through the peripheral bus.

## Interface
Parameters:
- `SCAN_T`, default 20'd50000: clock cycles per row slot. Legal range is 4 or more.
- `DEBOUNCE_N`, default 4: number of consecutive matching samples needed to accept a press or a release. Legal range is 2 to 15.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: reset, synchronous, active-high.
- `col_in` input 4: keypad columns, active-low, pulled up externally, asynchronous to `clk`.
- `rd_en` input 1: one-cycle CPU read acknowledge; clears `key_pending`.
- `row_out` output 4: row drive, active-low, exactly one bit low.
- `key_code` output 4: code of the last accepted key.
- `data` output 32: hex-digit accumulator.
- `data_en` output 1: one-cycle pulse when `data` or `key_code` updates.
- `key_pending` output 1: an accepted key has not yet been read.
- `overrun` output 1: a key was accepted while `key_pending` was already 1. Sticky.

## Operation
- `col_in` passes through a 2-flop synchronizer, giving `col_s`. All decisions use `col_s`.
- `cnt` counts 0..SCAN_T-1 and wraps. A *tick* occurs when `cnt == SCAN_T-1`. All sampling happens on ticks.
- Rotate means `row_out <= {row_out[2:0], row_out[3]}`. The row index r is the position of the 0 bit in `row_out`.
- Key code = r*4 + c, where c is the low column index. Example: row 2, col 2 gives 0xA.
- SCAN state, on a tick:
  - exactly one bit of `col_s` is 0: capture `col_s`, go to DEBOUNCE, set `mcnt = 1`, keep the row frozen;
  - otherwise (no bit low, or two or more bits low as a ghost or multi-press): rotate.
- DEBOUNCE state, on a tick:
  - `col_s` equals the captured value: `mcnt++`. When `mcnt` reaches DEBOUNCE_N, accept the key and go to WAIT_REL with `mcnt = 0`.
  - mismatch: go to SCAN, rotate, set `mcnt = 0`.
- WAIT_REL state, row stays frozen. On a tick:
  - `col_s == 4'hF`: `mcnt++`. When `mcnt` reaches DEBOUNCE_N, go to SCAN, rotate, set `mcnt = 0`.
  - any 0 in `col_s`: set `mcnt = 0`.
- Accept event, all on one edge:
  - `key_code <= code`;
  - `data <= {data[27:0], code}`;
  - `data_en <= 1` for one cycle;
  - `key_pending <= 1`;
  - `overrun <= 1` if `key_pending` was already 1.
- `rd_en` clears `key_pending`. If `rd_en` and an accept occur in the same cycle, set wins and `overrun` is unchanged.
- `overrun` is cleared only by `rst`.
- A press held indefinitely produces exactly one accept.

## Timing
- Reset values:
  - outputs: `row_out = 4'b1110`, `key_code = 0`, `data = 0`, `data_en = 0`, `key_pending = 0`, `overrun = 0`;
  - internal: state SCAN, `cnt = 0`, `mcnt = 0`, synchronizer `4'hF`.
- Reset is synchronous and takes effect on any cycle, including mid-DEBOUNCE or mid-WAIT_REL. No accept is generated after reset asserts.
- Synchronizer latency is 2 cycles. SCAN_T >= 4 guarantees `col_s` reflects the current row at the tick.
- Accept latency is at most (4 + DEBOUNCE_N) * SCAN_T + 2 cycles from a stable press. The press must have started while its row was driven.
- Outputs change on the edge at the final DEBOUNCE tick and are visible in the next cycle. `data_en` is high for exactly 1 cycle.
- `row_out` changes only on ticks. A full scan of all 4 rows with no key pressed takes 4*SCAN_T cycles.
- `data` wraps naturally: the oldest digit shifts out after 8 keys.

## Configuration
- `KEYPAD_ACCUM_EN` defined: `data` is the 8-digit shift accumulator described above.
- `KEYPAD_ACCUM_EN` undefined:
  - `data <= {28'b0, code}` on accept, so only the last key is held;
  - the shift logic is removed;
  - all other behaviour is identical.

## Test plan
Bench uses SCAN_T=4, DEBOUNCE_N=3, with `KEYPAD_ACCUM_EN` defined unless stated.
1. Assert `rst` for 2 cycles. Then: `row_out = 1110`, every other output is 0. With no key pressed, `row_out` cycles `1110`, `1101`, `1011`, `0111` every 4 cycles.
2. Hold row1/col2 low for 200 cycles. Exactly one `data_en` pulse occurs, with `key_code = 6`, `data = 0x00000006`, `key_pending = 1`. Scanning resumes only after release has been stable for 3 ticks.
3. Press and release keys 1, 2, 3, 0xA in turn, pulsing `rd_en` after each. Final `data = 0x0000123A` and `overrun = 0`. Without the macro, final `data = 0x0000000A`.
4. Hold col low for 1 tick then release (a bounce). There is no `data_en`, and the state returns to SCAN with the row rotating. Hold row0 col0 and col1 low together: no accept.
5. Accept two keys with no `rd_en` between them: `overrun = 1`. Then pulse `rd_en` in the same cycle as a third accept: `key_pending` stays 1.
6. Assert `rst` during DEBOUNCE, after the 2nd matching tick: no `data_en`, all outputs return to their reset values, and `data = 0`.
